// File: rtl/neo_pkg.sv
// Shared types and helpers for the Nonlinear Energy Operator sequencer.
// Optional threshold/spike logic elsewhere is enabled by defining NEO_THRESH_EN.
package neo_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StRda,
        StRdaCap,
        StRdb,
        StRdbCap,
        StFetch,
        StCapture,
        StCalc,
        StWrite,
        StDone
    } state_e;

    localparam int unsigned NDefault     = 16;
    localparam int unsigned ShiftDefault = 8;
    localparam int unsigned WideW        = 64;

    // Floor shift, then clamp into the signed n-bit range; caller truncates to n bits.
    function automatic logic signed [WideW-1:0] sat_shift(
        input logic signed [WideW-1:0] value,
        input int unsigned             shift,
        input int unsigned             n
    );
        logic signed [WideW-1:0] shifted;
        logic signed [WideW-1:0] hi;
        logic signed [WideW-1:0] lo;
        shifted = value >>> shift;
        hi      = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (n - 1));
        if (shifted > hi) begin
            return hi;
        end else if (shifted < lo) begin
            return lo;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/neo_seq_ctrl_calc.sv
// Registered psi datapath: x_cur^2 - x_prev*x_next, floor shift, saturate.
// With NEO_THRESH_EN defined it also registers a psi > thresh flag alongside psi.
module neo_calc
    import neo_pkg::*;
#(
    parameter int unsigned N     = NDefault,
    parameter int unsigned SHIFT = ShiftDefault
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                clr_i,
    input  logic signed [N-1:0] x_prev_i,
    input  logic signed [N-1:0] x_cur_i,
    input  logic signed [N-1:0] x_next_i,
`ifdef NEO_THRESH_EN
    input  logic signed [N-1:0] thresh_i,
    output logic                spike_o,
`endif
    output logic signed [N-1:0] psi_o
);

    logic signed [2*N-1:0]   xp_w, xc_w, xn_w;
    logic signed [2*N-1:0]   p_cc, p_pn;
    logic        [2*N:0]     diff;
    logic signed [WideW-1:0] diff_w;
    logic signed [N-1:0]     psi_d, psi_q;

    always_comb begin
        xp_w   = {{N{x_prev_i[N-1]}}, x_prev_i};
        xc_w   = {{N{x_cur_i[N-1]}}, x_cur_i};
        xn_w   = {{N{x_next_i[N-1]}}, x_next_i};
        p_cc   = xc_w * xc_w;
        p_pn   = xp_w * xn_w;
        diff   = {p_cc[2*N-1], p_cc} - {p_pn[2*N-1], p_pn};
        diff_w = {{(WideW-2*N-1){diff[2*N]}}, diff};
        psi_d  = N'(sat_shift(diff_w, SHIFT, N));
    end

    // psi is non-zero only while the WRITE cycle presents it on the memory port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psi_q <= '0;
        end else if (clr_i) begin
            psi_q <= '0;
        end else if (en_i) begin
            psi_q <= psi_d;
        end
    end

    assign psi_o = psi_q;

`ifdef NEO_THRESH_EN
    logic spike_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spike_q <= 1'b0;
        end else if (clr_i) begin
            spike_q <= 1'b0;
        end else if (en_i) begin
            spike_q <= (psi_d > thresh_i);
        end
    end

    assign spike_o = spike_q;
`endif

endmodule

// File: rtl/neo_seq_ctrl.sv
// NEO pass sequencer: streams samples from memory, writes psi results back, pulses done.
// Define NEO_THRESH_EN to add the thresh/spike/spike_cnt ports.
module neo_seq_ctrl
    import neo_pkg::*;
#(
    parameter int unsigned N         = NDefault,
    parameter int unsigned M         = 16,
    parameter int unsigned LEN       = 8,
    parameter int unsigned RES_BASE  = 8,
    parameter int unsigned PARK_ADDR = 15,
    parameter int unsigned SHIFT     = ShiftDefault,
    localparam int unsigned AW       = $clog2(M)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [AW-1:0]       mem_raddr_o,
    input  logic signed [N-1:0] mem_rdata_i,
    output logic [AW-1:0]       mem_waddr_o,
    output logic signed [N-1:0] mem_wdata_o,
    output logic                mem_we_o,
`ifdef NEO_THRESH_EN
    input  logic signed [N-1:0] thresh_i,
    output logic                spike_o,
    output logic [AW:0]         spike_cnt_o,
`endif
    output logic signed [N-1:0] psi_out_o
);

    if (LEN < 3) begin : g_chk_len
        $fatal(1, "neo_seq_ctrl: LEN must be at least 3");
    end
    if (RES_BASE + LEN - 2 > M) begin : g_chk_res
        $fatal(1, "neo_seq_ctrl: result region exceeds memory depth");
    end
    if (PARK_ADDR <= LEN - 1 || (PARK_ADDR >= RES_BASE && PARK_ADDR <= RES_BASE + LEN - 3))
    begin : g_chk_park
        $fatal(1, "neo_seq_ctrl: PARK_ADDR overlaps sample or result region");
    end

    state_e              state_q, state_d;
    logic [AW-1:0]       n_q, n_d;
    logic signed [N-1:0] x_prev_q, x_prev_d, x_cur_q, x_cur_d, x_next_q, x_next_d;
    logic [AW-1:0]       raddr_q, raddr_d, waddr_q, waddr_d;
    logic                we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic signed [N-1:0] psi_out_q, psi_out_d;
    logic signed [N-1:0] psi;
    logic                last_n;

    assign last_n = (n_q == AW'(LEN - 2));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start_i) state_d = StRda;
            StRda:     state_d = StRdaCap;
            StRdaCap:  state_d = StRdb;
            StRdb:     state_d = StRdbCap;
            StRdbCap:  state_d = StFetch;
            StFetch:   state_d = StCapture;
            StCapture: state_d = StCalc;
            StCalc:    state_d = StWrite;
            StWrite:   state_d = last_n ? StDone : StFetch;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output registers are loaded from the state being entered so they are valid in that state.
    always_comb begin
        n_d       = n_q;
        x_prev_d  = x_prev_q;
        x_cur_d   = x_cur_q;
        x_next_d  = x_next_q;
        psi_out_d = psi_out_q;
        raddr_d   = raddr_q;
        waddr_d   = AW'(PARK_ADDR);
        we_d      = 1'b0;
        done_d    = 1'b0;
        busy_d    = (state_d != StIdle);

        case (state_q)
            StRdaCap:  x_prev_d = mem_rdata_i;
            StRdbCap: begin
                x_cur_d = mem_rdata_i;
                n_d     = AW'(1);
            end
            StCapture: x_next_d = mem_rdata_i;
            StWrite: begin
                psi_out_d = psi;
                if (!last_n) begin
                    x_prev_d = x_cur_q;
                    x_cur_d  = x_next_q;
                    n_d      = n_q + AW'(1);
                end
            end
            default: ;
        endcase

        case (state_d)
            StRda:   raddr_d = '0;
            StRdb:   raddr_d = AW'(1);
            StFetch: raddr_d = n_d + AW'(1);
            StWrite: begin
                we_d    = 1'b1;
                waddr_d = AW'(RES_BASE) + n_q - AW'(1);
            end
            StDone:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_q       <= '0;
            x_prev_q  <= '0;
            x_cur_q   <= '0;
            x_next_q  <= '0;
            psi_out_q <= '0;
            raddr_q   <= '0;
            waddr_q   <= AW'(PARK_ADDR);
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            n_q       <= n_d;
            x_prev_q  <= x_prev_d;
            x_cur_q   <= x_cur_d;
            x_next_q  <= x_next_d;
            psi_out_q <= psi_out_d;
            raddr_q   <= raddr_d;
            waddr_q   <= waddr_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef NEO_THRESH_EN
    logic          spike;
    logic [AW:0]   spike_cnt_q, spike_cnt_d;

    always_comb begin
        spike_cnt_d = spike_cnt_q;
        if (state_q == StIdle && start_i) begin
            spike_cnt_d = '0;
        end else if (state_q == StWrite && spike) begin
            spike_cnt_d = spike_cnt_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spike_cnt_q <= '0;
        end else begin
            spike_cnt_q <= spike_cnt_d;
        end
    end

    assign spike_o     = spike;
    assign spike_cnt_o = spike_cnt_q;
`endif

    neo_calc #(
        .N     (N),
        .SHIFT (SHIFT)
    ) u_calc (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (state_q == StCalc),
        .clr_i    (state_q == StWrite),
        .x_prev_i (x_prev_q),
        .x_cur_i  (x_cur_q),
        .x_next_i (x_next_q),
`ifdef NEO_THRESH_EN
        .thresh_i (thresh_i),
        .spike_o  (spike),
`endif
        .psi_o    (psi)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign mem_raddr_o = raddr_q;
    assign mem_waddr_o = waddr_q;
    assign mem_wdata_o = psi;
    assign mem_we_o    = we_q;
    assign psi_out_o   = psi_out_q;

endmodule
